// File: rtl/fifo_pkg.sv
// Shared constants and the occupancy count type for the 8 x 32 synchronous FIFO
// (pointer/flag controller and storage array).
package fifo_pkg;

    localparam int FIFO_DEPTH    = 8;
    localparam int FIFO_WIDE     = 32;
    localparam int FIFO_PTR_WIDE = 3;

    typedef logic [FIFO_PTR_WIDE:0] fifo_count_t;

endpackage

// File: rtl/fifo_flag_gen_if.sv
// Request/status bundle between the FIFO flag generator and its users.
// Watermark signals exist only with FIFO_FLAG_GEN_WATERMARK_EN defined.
interface fifo_flag_gen_if;
    import fifo_pkg::*;

    logic                     wr_req;
    logic                     rd_req;
    logic                     wr_en;
    logic                     rd_en;
    logic [FIFO_PTR_WIDE-1:0] wr_addr;
    logic [FIFO_PTR_WIDE-1:0] rd_addr;
    logic                     full;
    logic                     empty;
    fifo_count_t              count;
    logic                     rd_valid;
    logic                     overflow;
    logic                     underflow;
`ifdef FIFO_FLAG_GEN_WATERMARK_EN
    logic                     almost_full;
    logic                     almost_empty;
`endif

    modport master (
        output wr_req, rd_req,
        input  wr_en, rd_en, wr_addr, rd_addr, full, empty, count,
               rd_valid, overflow, underflow
`ifdef FIFO_FLAG_GEN_WATERMARK_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  wr_req, rd_req,
        output wr_en, rd_en, wr_addr, rd_addr, full, empty, count,
               rd_valid, overflow, underflow
`ifdef FIFO_FLAG_GEN_WATERMARK_EN
        , output almost_full, almost_empty
`endif
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: the extra MSB distinguishes a full FIFO from an
// empty one when the address bits are equal.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int PTR_WIDE = FIFO_PTR_WIDE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PTR_WIDE:0] ptr
);

    logic [PTR_WIDE:0] ptr_r;

    // Advance modulo 2*depth on each accepted access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (inc) begin
            ptr_r <= ptr_r + {{PTR_WIDE{1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fifo_flag_gen.sv
// Pointer, occupancy and status controller for the 8-deep synchronous FIFO.
// Optional watermark flags: define FIFO_FLAG_GEN_WATERMARK_EN.
module fifo_flag_gen #(
    parameter int FIFO_DEPTH    = fifo_pkg::FIFO_DEPTH,
    parameter int FIFO_PTR_WIDE = fifo_pkg::FIFO_PTR_WIDE
`ifdef FIFO_FLAG_GEN_WATERMARK_EN
    ,
    parameter int AF_LEVEL      = 6,
    parameter int AE_LEVEL      = 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    fifo_flag_gen_if.slave   bus
);

    localparam logic [FIFO_PTR_WIDE:0] DEPTH_C = (FIFO_PTR_WIDE+1)'(FIFO_DEPTH);
    localparam logic [FIFO_PTR_WIDE:0] ONE_C   = (FIFO_PTR_WIDE+1)'(1);

    logic                   wr_acc_s;
    logic                   rd_acc_s;
    logic [FIFO_PTR_WIDE:0] wr_ptr_s;
    logic [FIFO_PTR_WIDE:0] rd_ptr_s;
    logic [FIFO_PTR_WIDE:0] count_nxt_s;
    logic [FIFO_PTR_WIDE:0] count_r;
    logic                   full_r;
    logic                   empty_r;
    logic                   rd_valid_r;
    logic                   overflow_r;
    logic                   underflow_r;

    fifo_ptr #(.PTR_WIDE(FIFO_PTR_WIDE)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc_s),
        .ptr (wr_ptr_s)
    );

    fifo_ptr #(.PTR_WIDE(FIFO_PTR_WIDE)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc_s),
        .ptr (rd_ptr_s)
    );

    // Acceptance gating and next occupancy; a refused side never moves count.
    always_comb begin
        wr_acc_s    = bus.wr_req & ~full_r;
        rd_acc_s    = bus.rd_req & ~empty_r;
        count_nxt_s = count_r;
        if (wr_acc_s & ~rd_acc_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (rd_acc_s & ~wr_acc_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count, flags from next-state count, sticky errors and read-valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == DEPTH_C);
            empty_r     <= (count_nxt_s == '0);
            rd_valid_r  <= rd_acc_s;
            overflow_r  <= overflow_r | (bus.wr_req & full_r);
            underflow_r <= underflow_r | (bus.rd_req & empty_r);
        end
    end

`ifdef FIFO_FLAG_GEN_WATERMARK_EN
    localparam logic [FIFO_PTR_WIDE:0] AF_C = (FIFO_PTR_WIDE+1)'(AF_LEVEL);
    localparam logic [FIFO_PTR_WIDE:0] AE_C = (FIFO_PTR_WIDE+1)'(AE_LEVEL);

    logic almost_full_r;
    logic almost_empty_r;

    // Watermark flags, evaluated on the same next-state count as full/empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            almost_full_r  <= (count_nxt_s >= AF_C);
            almost_empty_r <= (count_nxt_s <= AE_C);
        end
    end

    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
`endif

    // The array re-applies full/empty gating, so raw requests pass straight through.
    assign bus.wr_en     = bus.wr_req;
    assign bus.rd_en     = bus.rd_req;
    assign bus.wr_addr   = wr_ptr_s[FIFO_PTR_WIDE-1:0];
    assign bus.rd_addr   = rd_ptr_s[FIFO_PTR_WIDE-1:0];
    assign bus.full      = full_r;
    assign bus.empty     = empty_r;
    assign bus.count     = count_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;

endmodule

// File: doc/fifo_flag_gen.md
# fifo_flag_gen

Pointer and status controller for the 8-deep × 32-bit synchronous FIFO. It sits directly upstream of the FIFO storage array and is the only driver of the array's `wr_en`, `rd_en`, `wr_addr`, `rd_addr`, `full` and `empty` inputs. It accepts raw push and pop requests from the producer and consumer, advances the write and read pointers, and keeps an occupancy count. It publishes registered full, empty and watermark flags, sticky overflow and underflow errors, and a read-data-valid strobe aligned with the array's registered read port.

## Interface
- `FIFO_DEPTH`, 8, number of entries; must equal 2**`FIFO_PTR_WIDE`.
- `FIFO_PTR_WIDE`, 3, address width of `wr_addr` and `rd_addr`.
- `AF_LEVEL`, 6, `almost_full` asserts when count ≥ `AF_LEVEL`.
- `AE_LEVEL`, 2, `almost_empty` asserts when count ≤ `AE_LEVEL`.
- `clk` in 1 — the single clock; all state updates on its rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `wr_req` in 1 — producer push request.
- `rd_req` in 1 — consumer pop request.
- `wr_en` out 1 — write strobe to the array; equals `wr_req`.
- `rd_en` out 1 — read strobe to the array; equals `rd_req`.
- `wr_addr` out `FIFO_PTR_WIDE` — write pointer to the array.
- `rd_addr` out `FIFO_PTR_WIDE` — read pointer to the array.
- `full` out 1 — registered; count == `FIFO_DEPTH`.
- `empty` out 1 — registered; count == 0.
- `almost_full` out 1 — registered watermark flag (only when the macro is defined).
- `almost_empty` out 1 — registered watermark flag (only when the macro is defined).
- `count` out `FIFO_PTR_WIDE`+1 — occupancy, range 0..`FIFO_DEPTH`.
- `rd_valid` out 1 — array `data_out` is valid this cycle.
- `overflow` out 1 — sticky error flag.
- `underflow` out 1 — sticky error flag.

## Operation
- Write accept: `wr_acc = wr_req & ~full`. Read accept: `rd_acc = rd_req & ~empty`. The array applies the same gating internally, because `full` and `empty` are shared with it.
- Internal pointers are `FIFO_PTR_WIDE`+1 bits wide, with the MSB used as a wrap bit.
  - `wr_addr` and `rd_addr` are the low `FIFO_PTR_WIDE` bits.
  - On an accepted access the pointer increments modulo 2·`FIFO_DEPTH`, so the address wraps 7→0.
- Count update:
  - +1 on `wr_acc & ~rd_acc`.
  - −1 on `rd_acc & ~wr_acc`.
  - Unchanged when both or neither are accepted.
- Flags are computed from next-state count and registered, so they are always consistent with `count`.
- Full and simultaneous push+pop: the write is refused and the read proceeds. Next cycle count = 7 and `full` = 0.
- Empty and simultaneous push+pop: the read is refused and the write proceeds. Next cycle count = 1 and `empty` = 0.
- `overflow` sets on `wr_req & full`; `underflow` sets on `rd_req & empty`. Both hold until `rst`.
- Invariant: `wr_ptr − rd_ptr` (modulo 2·`FIFO_DEPTH`) == `count` in every cycle.

## Timing
- Reset values: pointers 0, `count` 0, `empty` 1, `full` 0, `almost_empty` 1, `almost_full` 0, `rd_valid` 0, `overflow` 0, `underflow` 0.
- Reset mid-operation discards all contents immediately (asynchronous). The first request is accepted on the first rising edge after `rst` falls.
- `wr_en`, `rd_en`, `wr_addr` and `rd_addr` are presented in the same cycle as the request; the array samples them on that edge.
- Flags and `count` reflect an accepted access one cycle after the edge that accepted it.
- `rd_valid` is a registered `rd_acc`. It is high in the cycle after an accepted read, together with the array's `data_out`.
- Throughput is one push and one pop per cycle, with no bubbles.

## Configuration
- Macro: `FIFO_FLAG_GEN_WATERMARK_EN`.
- Defined: `almost_full` and `almost_empty` ports and their registers exist, driven per `AF_LEVEL` and `AE_LEVEL`.
- Undefined: neither port nor its logic exists, and `AF_LEVEL`/`AE_LEVEL` are unused. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg`:
  - Default `FIFO_DEPTH`, `FIFO_WIDE` and `FIFO_PTR_WIDE` constants.
  - A count type of width `FIFO_PTR_WIDE`+1, shared with the array.
- One sub-module, `fifo_ptr`: a wrap-bit pointer register with an increment enable, instantiated twice (write and read).
- The top level holds the count, flags, errors and `rd_valid`.

## Test plan
- After reset, push 8 words 0x1..0x8 on consecutive cycles → `full` = 1 one cycle after the 8th push; `count` = 8; `wr_addr` wrapped to 0.
- With the FIFO full, push 0xDEAD → array not written, `overflow` = 1 and it stays 1 until `rst`. A pop then returns 0x1 with `rd_valid` = 1 one cycle after `rd_req`.
- With the FIFO full, assert `wr_req` and `rd_req` together for one cycle → read accepted, write refused; `count` = 7, `full` = 0.
- With the FIFO empty, assert `wr_req` and `rd_req` together → write accepted, read refused; `count` = 1, `rd_valid` = 0, `underflow` = 1.
- With the macro defined, fill to 6 → `almost_full` = 1. Drain to 2 → `almost_empty` = 1.
- Assert `rst` mid-burst at count 5 → all outputs return to their reset values immediately; the next push lands at `wr_addr` = 0.
